// File: rtl/dmem_resp_if.sv
// Data-memory request/response bundle between processor and dmem_resp.
// Ports: memwrite/memread/dataadr/writedata in; readdata/ready/flags out.
interface dmem_resp_if;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        misalign;
  logic        pass;
  logic        fail;

  modport master (
    output memwrite,
    output memread,
    output dataadr,
    output writedata,
    input  readdata,
    input  ready,
    input  misalign,
    input  pass,
    input  fail
  );

  modport slave (
    input  memwrite,
    input  memread,
    input  dataadr,
    input  writedata,
    output readdata,
    output ready,
    output misalign,
    output pass,
    output fail
  );
endinterface

// File: rtl/dmem_resp.sv
// Wait-stated word memory with a ready pulse and sticky write checker.
// Ports: clk, reset (async active-low), bus (dmem_resp_if.slave).
// Define DMEM_RESP_CHECK_EN to build the pass/fail checker.
module dmem_resp #(
  parameter int unsigned WORDS    = 64,
  parameter int unsigned WAIT     = 2,
  parameter logic [31:0] CHK_ADDR = 32'd84,
  parameter logic [31:0] CHK_DATA = 32'd7,
  parameter logic [31:0] IGN_ADDR = 32'd80
) (
  input logic         clk,
  input logic         reset,
  dmem_resp_if.slave  bus
);

  localparam int unsigned IW = $clog2(WORDS);
  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          nstate;
  logic [3:0]      cnt;
  logic            op_wr;
  logic            op_mis;
  logic [IW-1:0]   idx;
  logic [31:0]     wdata;
  logic            mis_q;
  logic [31:0]     mem [WORDS];

  logic            req;
  logic            mis_in;
  logic            commit;

  assign req    = bus.memwrite | bus.memread;
  assign mis_in = |bus.dataadr[1:0];
  assign commit = (state == S_RESP) & op_wr & ~op_mis;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (req) nstate = S_WAIT;
      S_WAIT: if (cnt == 4'd0) nstate = S_RESP;
      S_RESP: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready    = 1'b0;
    bus.readdata = 32'd0;
    if (state == S_RESP) begin
      bus.ready = 1'b1;
      if (!op_wr && !op_mis) bus.readdata = mem[idx];
    end
  end

  // Request is captured only in IDLE; the bus may change freely afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      op_wr  <= 1'b0;
      op_mis <= 1'b0;
      idx    <= '0;
      wdata  <= 32'd0;
      mis_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            cnt    <= CNT_INIT;
            op_wr  <= bus.memwrite;
            op_mis <= mis_in;
            idx    <= bus.dataadr[IW+1:2];
            wdata  <= bus.writedata;
            if (mis_in) mis_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Array is not reset; a reset forces IDLE so an abandoned write never lands.
  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= wdata;
  end

  assign bus.misalign = mis_q;

`ifdef DMEM_RESP_CHECK_EN
  logic [31:0] addr_q;
  logic        pass_q;
  logic        fail_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   addr_q <= 32'd0;
    else if (state == S_IDLE && req) addr_q <= bus.dataadr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (commit) begin
      if (addr_q == CHK_ADDR) begin
        if (wdata == CHK_DATA) pass_q <= 1'b1;
        else                   fail_q <= 1'b1;
      end else if (addr_q != IGN_ADDR) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
`else
  logic unused_adr;
  assign unused_adr = ^bus.dataadr[31:IW+2];
  assign bus.pass   = 1'b0;
  assign bus.fail   = 1'b0;
`endif

endmodule
